// File: rtl/platform_onchip_mem_arbiter_if.sv
// Bus bundle between the two Avalon-MM masters, the arbiter and the on-chip RAM s1 port.
// slave = arbiter view, master = environment (masters + RAM) view.
interface platform_onchip_mem_arbiter_if #(
   parameter int ADDR_W = 15,
   parameter int DATA_W = 32
);
   localparam int BE_W = DATA_W / 8;

   logic [ADDR_W-1:0] m0_address,    m1_address;
   logic [BE_W-1:0]   m0_byteenable, m1_byteenable;
   logic              m0_read,       m1_read;
   logic              m0_write,      m1_write;
   logic [DATA_W-1:0] m0_writedata,  m1_writedata;
   logic              m0_waitrequest,   m1_waitrequest;
   logic [DATA_W-1:0] m0_readdata,      m1_readdata;
   logic              m0_readdatavalid, m1_readdatavalid;

   logic [ADDR_W-1:0] mem_address;
   logic [BE_W-1:0]   mem_byteenable;
   logic              mem_chipselect;
   logic              mem_write;
   logic [DATA_W-1:0] mem_writedata;
   logic [DATA_W-1:0] mem_readdata;
   logic              mem_clken;

   modport slave (
      input  m0_address, m0_byteenable, m0_read, m0_write, m0_writedata,
      input  m1_address, m1_byteenable, m1_read, m1_write, m1_writedata,
      output m0_waitrequest, m0_readdata, m0_readdatavalid,
      output m1_waitrequest, m1_readdata, m1_readdatavalid,
      output mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata, mem_clken,
      input  mem_readdata
   );

   modport master (
      output m0_address, m0_byteenable, m0_read, m0_write, m0_writedata,
      output m1_address, m1_byteenable, m1_read, m1_write, m1_writedata,
      input  m0_waitrequest, m0_readdata, m0_readdatavalid,
      input  m1_waitrequest, m1_readdata, m1_readdatavalid,
      input  mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata, mem_clken,
      output mem_readdata
   );
endinterface

// File: rtl/platform_onchip_mem_arbiter.sv
// Two-master arbiter for the single-port on-chip RAM: command stage C, response stage R, output stage O.
// Define ONCHIP_ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority (m0 wins).
module platform_onchip_mem_arbiter #(
   parameter int ADDR_W = 15,
   parameter int DATA_W = 32
) (
   input  logic clk,
   input  logic reset_n,
   input  logic freeze,
   platform_onchip_mem_arbiter_if.slave bus
);
   localparam int BE_W = DATA_W / 8;

   typedef struct packed {
      logic              vld;
      logic              wr;
      logic              rd;
      logic              id;
      logic [ADDR_W-1:0] addr;
      logic [BE_W-1:0]   be;
      logic [DATA_W-1:0] wdata;
   } cmd_t;

   logic [1:0]        req, gnt;
   cmd_t [1:0]        cmd_in;
   cmd_t              c_q;
   logic              r_vld, r_id;
   logic              o_vld, o_id;
   logic [DATA_W-1:0] o_data;

   // Read+write together is a write; the read half is dropped.
   always_comb begin
      cmd_in          = '0;
      req[0]          = bus.m0_read | bus.m0_write;
      req[1]          = bus.m1_read | bus.m1_write;
      cmd_in[0].vld   = 1'b1;
      cmd_in[0].wr    = bus.m0_write;
      cmd_in[0].rd    = bus.m0_read & ~bus.m0_write;
      cmd_in[0].id    = 1'b0;
      cmd_in[0].addr  = bus.m0_address;
      cmd_in[0].be    = bus.m0_byteenable;
      cmd_in[0].wdata = bus.m0_writedata;
      cmd_in[1].vld   = 1'b1;
      cmd_in[1].wr    = bus.m1_write;
      cmd_in[1].rd    = bus.m1_read & ~bus.m1_write;
      cmd_in[1].id    = 1'b1;
      cmd_in[1].addr  = bus.m1_address;
      cmd_in[1].be    = bus.m1_byteenable;
      cmd_in[1].wdata = bus.m1_writedata;
   end

`ifdef ONCHIP_ARB_ROUND_ROBIN_EN
   // last_id = master granted most recently; reset value 0 lets m1 win the first tie.
   logic last_id;

   always_comb begin
      gnt = '0;
      if (reset_n && !freeze) begin
         if (req == 2'b11) gnt = last_id ? 2'b01 : 2'b10;
         else              gnt = req;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)  last_id <= 1'b0;
      else if (|gnt) last_id <= gnt[1];
   end
`else
   always_comb begin
      gnt = '0;
      if (reset_n && !freeze) begin
         gnt[0] = req[0];
         gnt[1] = req[1] & ~req[0];
      end
   end
`endif

   // Payload holds when idle; only the valid bit is cleared.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)    c_q     <= '0;
      else if (|gnt)   c_q     <= gnt[1] ? cmd_in[1] : cmd_in[0];
      else             c_q.vld <= 1'b0;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_vld  <= 1'b0;
         r_id   <= 1'b0;
         o_vld  <= 1'b0;
         o_id   <= 1'b0;
         o_data <= '0;
      end else begin
         r_vld <= c_q.vld & c_q.rd;
         r_id  <= c_q.id;
         o_vld <= r_vld;
         o_id  <= r_id;
         if (r_vld) o_data <= bus.mem_readdata;
      end
   end

   assign bus.m0_waitrequest   = ~gnt[0];
   assign bus.m1_waitrequest   = ~gnt[1];
   assign bus.m0_readdata      = o_data;
   assign bus.m1_readdata      = o_data;
   assign bus.m0_readdatavalid = o_vld & ~o_id;
   assign bus.m1_readdatavalid = o_vld &  o_id;

   assign bus.mem_address    = c_q.addr;
   assign bus.mem_byteenable = c_q.be;
   assign bus.mem_writedata  = c_q.wdata;
   assign bus.mem_chipselect = c_q.vld;
   assign bus.mem_write      = c_q.vld & c_q.wr;
   assign bus.mem_clken      = 1'b1;
endmodule

// File: tb/tb_platform_onchip_mem_arbiter.sv
// Scoreboard bench: a reference memory predicts read data at acceptance; a negedge monitor pops and compares.
module tb_platform_onchip_mem_arbiter;
   localparam int ADDR_W = 15;
   localparam int DATA_W = 32;

   typedef struct {
      int          due;
      logic        id;
      logic [31:0] data;
   } sb_t;

   logic clk = 1'b0, reset_n = 1'b0, freeze = 1'b0;
   int   cyc = 0, n_vec = 0, n_err = 0;
   sb_t  sb[$];

   logic [31:0] ram     [0:32767];
   logic [31:0] ref_mem [0:32767];
   logic [14:0] ram_addr_q = '0;
   logic [14:0] addrs [4] = '{15'h0010, 15'h0020, 15'h0030, 15'h7FFF};

   platform_onchip_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   platform_onchip_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .freeze  (freeze),
      .bus     (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d, input logic [3:0] be);
      logic [31:0] w;
      w = old;
      for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = d[8*b +: 8];
      return w;
   endfunction

   // RAM model: registered address, unregistered q.
   always @(posedge clk) begin
      if (bus.mem_clken) begin
         ram_addr_q <= bus.mem_address;
         if (bus.mem_chipselect && bus.mem_write)
            ram[bus.mem_address] <= merge(ram[bus.mem_address], bus.mem_writedata, bus.mem_byteenable);
      end
   end
   assign bus.mem_readdata = ram[ram_addr_q];

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   // Monitor: response strobes every cycle, data when a prediction falls due.
   logic mon_e0, mon_e1;
   sb_t  mon_e;
   always @(negedge clk) begin
      mon_e0 = 1'b0;
      mon_e1 = 1'b0;
      if (sb.size() > 0 && sb[0].due == cyc) begin
         mon_e = sb.pop_front();
         if (mon_e.id) begin
            mon_e1 = 1'b1;
            chk("rdata1", bus.m1_readdata, mon_e.data);
         end else begin
            mon_e0 = 1'b1;
            chk("rdata0", bus.m0_readdata, mon_e.data);
         end
      end
      chk("rdv0", bus.m0_readdatavalid, mon_e0);
      chk("rdv1", bus.m1_readdatavalid, mon_e1);
   end

   task automatic accept(input logic id, input logic r, input logic w, input logic [14:0] a,
                         input logic [3:0] be, input logic [31:0] d);
      if (w)      ref_mem[a] = merge(ref_mem[a], d, be);
      else if (r) sb.push_back('{due: cyc + 3, id: id, data: ref_mem[a]});
   endtask

   task automatic drive(input logic fz, input logic r0, input logic w0, input logic [14:0] a0,
                        input logic [3:0] be0, input logic [31:0] d0, input logic r1, input logic w1,
                        input logic [14:0] a1, input logic [3:0] be1, input logic [31:0] d1);
      freeze = fz;
      bus.m0_read = r0; bus.m0_write = w0; bus.m0_address = a0; bus.m0_byteenable = be0; bus.m0_writedata = d0;
      bus.m1_read = r1; bus.m1_write = w1; bus.m1_address = a1; bus.m1_byteenable = be1; bus.m1_writedata = d1;
   endtask

   // One cycle of stimulus; eg = expected grant vector {m1, m0}.
   task automatic issue(input logic fz, input logic r0, input logic w0, input logic [14:0] a0,
                        input logic [3:0] be0, input logic [31:0] d0, input logic r1, input logic w1,
                        input logic [14:0] a1, input logic [3:0] be1, input logic [31:0] d1,
                        input logic [1:0] eg);
      @(negedge clk); #1;
      drive(fz, r0, w0, a0, be0, d0, r1, w1, a1, be1, d1);
      #1;
      chk("wait0", bus.m0_waitrequest, !eg[0]);
      chk("wait1", bus.m1_waitrequest, !eg[1]);
      if (eg[0]) accept(1'b0, r0, w0, a0, be0, d0);
      if (eg[1]) accept(1'b1, r1, w1, a1, be1, d1);
   endtask

   task automatic rd(input logic id, input logic [14:0] a);
      if (id) issue(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b1, 1'b0, a, 4'hF, '0, 2'b10);
      else    issue(1'b0, 1'b1, 1'b0, a, 4'hF, '0, 1'b0, 1'b0, '0, '0, '0, 2'b01);
   endtask

   task automatic wr(input logic id, input logic [14:0] a, input logic [3:0] be, input logic [31:0] d);
      if (id) issue(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b1, a, be, d, 2'b10);
      else    issue(1'b0, 1'b0, 1'b1, a, be, d, 1'b0, 1'b0, '0, '0, '0, 2'b01);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) issue(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, '0, '0, '0, 2'b00);
   endtask

   task automatic chk_reset();
      chk("rst_wait0", bus.m0_waitrequest, 1'b1);
      chk("rst_wait1", bus.m1_waitrequest, 1'b1);
      chk("rst_rdv0",  bus.m0_readdatavalid, 1'b0);
      chk("rst_rdv1",  bus.m1_readdatavalid, 1'b0);
      chk("rst_cs",    bus.mem_chipselect, 1'b0);
      chk("rst_mwr",   bus.mem_write, 1'b0);
      chk("rst_rdata", bus.m0_readdata, 32'h0);
      chk("rst_maddr", bus.mem_address, 15'h0);
      chk("rst_mwd",   bus.mem_writedata, 32'h0);
      chk("rst_clken", bus.mem_clken, 1'b1);
   endtask

   task automatic pulse_reset(input logic busy);
      @(negedge clk); #1;
      reset_n = 1'b0;
      sb.delete();
      drive(1'b0, busy, 1'b0, 15'h0010, 4'hF, '0, busy, 1'b0, 15'h0020, 4'hF, '0);
      #1;
      chk_reset();
      @(negedge clk); #1;
      reset_n = 1'b1;
      drive(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, '0, '0, '0);
   endtask

   initial begin
      #300000;
      chk("timeout", 1'b0, 1'b1);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      int         i0, i1;
      logic [1:0] eg;
      drive(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0, 1'b0, '0, '0, '0);
      #2;
      chk_reset();
      @(negedge clk); #1;
      reset_n = 1'b1;
      idle(2);

      // single read, m1 must stay silent
      wr(1'b0, 15'h0010, 4'hF, 32'hDEADBEEF);
      rd(1'b0, 15'h0010);
      idle(4);

      // byte enables: expect 0x1122CC44
      wr(1'b1, 15'h0020, 4'hF, 32'h11223344);
      wr(1'b1, 15'h0020, 4'h2, 32'hAABBCCDD);
      rd(1'b1, 15'h0020);
      idle(4);

      // read-after-write across masters at top address
      wr(1'b0, 15'h7FFF, 4'hF, 32'h00000005);
      rd(1'b1, 15'h7FFF);
      idle(4);

      // read+write together acts as a write with no response
      issue(1'b0, 1'b1, 1'b1, 15'h0030, 4'hF, 32'h12345678, 1'b0, 1'b0, '0, '0, '0, 2'b01);
      rd(1'b0, 15'h0030);
      idle(4);

      // contention from a fresh arbiter state
      pulse_reset(1'b0);
      i0 = 0;
      i1 = 2;
      for (int k = 0; k < 4; k++) begin
`ifdef ONCHIP_ARB_ROUND_ROBIN_EN
         eg = (k % 2 == 0) ? 2'b10 : 2'b01;
`else
         eg = 2'b01;
`endif
         issue(1'b0, 1'b1, 1'b0, addrs[i0], 4'hF, '0, 1'b1, 1'b0, addrs[i1], 4'hF, '0, eg);
         if (eg[0]) i0 = (i0 + 1) % 4;
         if (eg[1]) i1 = (i1 + 1) % 4;
      end
      idle(4);

      // freeze with a read in flight
      rd(1'b0, 15'h0010);
      for (int k = 0; k < 3; k++)
         issue(1'b1, 1'b1, 1'b0, 15'h0010, 4'hF, '0, 1'b1, 1'b0, 15'h0020, 4'hF, '0, 2'b00);
`ifdef ONCHIP_ARB_ROUND_ROBIN_EN
      eg = 2'b10;
`else
      eg = 2'b01;
`endif
      issue(1'b0, 1'b1, 1'b0, 15'h0010, 4'hF, '0, 1'b1, 1'b0, 15'h0020, 4'hF, '0, eg);
      idle(5);

      // reset one cycle after a read is accepted: the response must never appear
      rd(1'b0, 15'h0010);
      pulse_reset(1'b1);
      idle(6);

      chk("drain", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/platform_onchip_mem_arbiter.md
# platform_onchip_mem_arbiter

Two-master Avalon-MM arbiter sharing the single-port 32K x 32 on-chip RAM (`platform_onchip_memory`: registered address, unregistered q, byte enables). Sits between two bus masters (CPU data port and DMA) and the RAM's s1 port, pipelined at one command per cycle. Read responses return in order, tagged to the issuing master, at fixed latency.

## Interface
Parameters:
- ADDR_W, 15, word address width (32768 words)
- DATA_W, 32, data width; BE_W = DATA_W/8

Ports:
- clk  in  1  sole clock
- reset_n  in  1  asynchronous, active-low reset
- freeze  in  1  1 = issue no new grants; in-flight pipeline keeps draining
- mX_address  in  ADDR_W  master X word address (X = 0, 1)
- mX_byteenable  in  BE_W  master X byte enables
- mX_read / mX_write  in  1  master X command strobes
- mX_writedata  in  DATA_W  master X write data
- mX_waitrequest  out  1  1 = command not accepted this cycle
- mX_readdata  out  DATA_W  read response data
- mX_readdatavalid  out  1  one-cycle response strobe
- mem_address  out  ADDR_W  to RAM address
- mem_byteenable  out  BE_W  to RAM byteenable
- mem_chipselect  out  1  to RAM chipselect
- mem_write  out  1  to RAM write
- mem_writedata  out  DATA_W  to RAM writedata
- mem_readdata  in  DATA_W  from RAM readdata
- mem_clken  out  1  to RAM clken, constant 1

## Operation
- Request: req_X = mX_read | mX_write. Grant combinational same cycle; grant only if freeze = 0.
- mX_waitrequest = ~grant_X (high when not requesting, granted elsewhere, frozen, or in reset).
- Accepted command (req_X & grant_X) captured at the clock edge into command stage C: address, byteenable, writedata, write, read, master id, valid.
- Stage C drives mem_*: mem_chipselect = C.valid, mem_write = C.valid & C.write. RAM captures at end of C cycle.
- Response stage R: if C held a read, at next edge R.valid=1, R.id=C.id. Output stage O registers mem_readdata while R.valid, then strobes mX_readdatavalid for R.id only.
- mX_readdata = O data for both ports (validity via readdatavalid only).
- mX_read and mX_write both high: treated as write; read ignored, no response.
- Writes produce no response. Reads and writes execute in acceptance order; read after write to same address returns the new data.
- Masters cannot backpressure responses; readdatavalid is never held.
- Reset: C, R, O valid cleared, round-robin pointer = 0 (m1 favoured first), all mX_readdatavalid = 0, mem_chipselect = 0, mem_write = 0, mX_readdata and mem_address/writedata = 0.
- Reset mid-operation: in-flight reads discarded, no responses after deassertion; RAM contents untouched by arbiter.
- freeze rising mid-burst: waitrequest high next evaluation; already-accepted reads still return.

## Timing
- Throughput: one accepted command per cycle total, either master.
- Read latency: accept in cycle N -> mX_readdatavalid high in cycle N+3.
- Write: RAM written at end of cycle N+1.
- Back-to-back reads from alternating masters: responses in cycles N+3, N+4, ... in same order.
- No combinational path from mem_readdata to any output; the only combinational path is mX_read/mX_write/freeze -> mX_waitrequest.

## Configuration
- ONCHIP_ARB_ROUND_ROBIN_EN defined: both requesting -> grant master not granted last; pointer updates only on accepted command; single requester always granted.
- Undefined: fixed priority, m0 always wins; m1 granted only when m0 idle. Pointer register absent.

## Test plan
- Single read: write 0xDEADBEEF to addr 0x0010 via m0 (be=0xF), m0 read 0x0010 in cycle N -> m0_readdatavalid in N+3 with 0xDEADBEEF, m1_readdatavalid stays 0.
- Byte enables: write 0x11223344, then be=0x2 data 0xAABBCCDD, read -> 0x1122CC44.
- Contention, round-robin build: both masters read continuously 4 cycles -> grants m1,m0,m1,m0; responses alternate with matching ids. Fixed build: m0 four grants, m1 waitrequest high throughout.
- Read-after-write: m0 writes 0x5 to 0x7FFF, m1 reads 0x7FFF next cycle -> m1 gets 0x5.
- freeze=1 for 3 cycles with both requesting -> both waitrequest high, earlier in-flight read still returns at N+3; grants resume cycle after freeze falls.
- reset_n pulsed low one cycle after read accept -> no readdatavalid afterwards, all outputs at reset values during reset.
